// File: rtl/lr_d_sched_pkg.sv
// Shared types and defaults for the leaky-ReLU derivative scheduler.
// Holds the FSM state encoding and the lane/data defaults.
package lr_d_sched_pkg;

    localparam int DEF_LANES  = 4;
    localparam int DEF_DATA_W = 16;
    localparam int RD_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/lr_d_skew_chain.sv
// Single-bit systolic skew chain: lane i sees the read strobe i+1 cycles late.
// Bubbles (zeros) travel down the chain like any other value.
module lr_d_skew_chain
    import lr_d_sched_pkg::*;
#(
    parameter int LANES = DEF_LANES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    output logic [LANES-1:0] lane_valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_valid <= '0;
        end else begin
            for (int i = LANES - 1; i > 0; i--) begin
                lane_valid[i] <= lane_valid[i-1];
            end
            lane_valid[0] <= rd_en;
        end
    end

endmodule

// File: rtl/leaky_relu_derivative_scheduler.sv
// Backward-pass scheduler for a bank of leaky-ReLU derivative lanes.
// Issues one buffer read per row, skews lane valids, then pulses done.
module leaky_relu_derivative_scheduler
    import lr_d_sched_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int ROW_W  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_in,
    input  logic [ROW_W-1:0]  num_rows_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [DATA_W-1:0] leak_factor_in,
    input  logic              ub_ready_in,
    output logic              rd_en_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic [LANES-1:0]  lane_valid_out,
    output logic [DATA_W-1:0] leak_factor_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t state;
    state_t next_state;

    logic [ROW_W-1:0]  num_rows;
    logic [ROW_W-1:0]  row_cnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] leak;
    logic [CNT_W-1:0]  drain_cnt;
    logic              accept;
    logic              last_read;

    assign accept    = (state == IDLE) && start_in;
    assign last_read = rd_en_out && (row_cnt == num_rows - ROW_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start_in) begin
                    next_state = (num_rows_in == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (last_read) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_en_out = 1'b0;
        busy_out  = 1'b0;
        done_out  = 1'b0;
        unique case (state)
            IDLE: begin
                busy_out = 1'b0;
            end
            ISSUE: begin
                rd_en_out = ub_ready_in;
                busy_out  = 1'b1;
            end
            DRAIN: begin
                busy_out = 1'b1;
            end
            DONE: begin
                busy_out = 1'b1;
                done_out = 1'b1;
            end
            default: begin
                busy_out = 1'b0;
            end
        endcase
    end

    // The address register tracks base + row_cnt so the strobe needs no adder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_rows <= '0;
            row_cnt  <= '0;
            addr     <= '0;
            leak     <= '0;
        end else if (accept) begin
            num_rows <= num_rows_in;
            row_cnt  <= '0;
            addr     <= base_addr_in;
            leak     <= leak_factor_in;
        end else if (rd_en_out) begin
            row_cnt <= row_cnt + ROW_W'(1);
            addr    <= addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (state == ISSUE && last_read) begin
            drain_cnt <= CNT_W'(LANES - 1);
        end else if (state == DRAIN && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - CNT_W'(1);
        end
    end

    lr_d_skew_chain #(
        .LANES(LANES)
    ) u_skew (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en_out),
        .lane_valid (lane_valid_out)
    );

    assign rd_addr_out     = addr;
    assign leak_factor_out = leak;

endmodule

// File: tb/tb_leaky_relu_derivative_scheduler.sv
// Self-checking bench for leaky_relu_derivative_scheduler.
// Directed job table, reset sequences and random jobs against a reference model.
module tb_leaky_relu_derivative_scheduler;

    localparam int LANES  = 4;
    localparam int ROW_W  = 8;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_in = 1'b0;
    logic [ROW_W-1:0]  num_rows_in = '0;
    logic [ADDR_W-1:0] base_addr_in = '0;
    logic [DATA_W-1:0] leak_factor_in = '0;
    logic              ub_ready_in = 1'b0;
    logic              rd_en_out;
    logic [ADDR_W-1:0] rd_addr_out;
    logic [LANES-1:0]  lane_valid_out;
    logic [DATA_W-1:0] leak_factor_out;
    logic              busy_out;
    logic              done_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    leaky_relu_derivative_scheduler #(
        .LANES (LANES),
        .ROW_W (ROW_W),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_in       (start_in),
        .num_rows_in    (num_rows_in),
        .base_addr_in   (base_addr_in),
        .leak_factor_in (leak_factor_in),
        .ub_ready_in    (ub_ready_in),
        .rd_en_out      (rd_en_out),
        .rd_addr_out    (rd_addr_out),
        .lane_valid_out (lane_valid_out),
        .leak_factor_out(leak_factor_out),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    typedef struct {
        int          rows;
        logic [15:0] base;
        logic [15:0] leak;
        logic [63:0] mask;
        int          inj;
        int          exp_done;
        int          exp_reads;
    } job_t;

    task automatic check(input string name, input int cyc,
                         input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {25'd0, rd_en_out, rd_addr_out, lane_valid_out,
                leak_factor_out, busy_out, done_out};
    endfunction

    // Reference: reads happen on ready issue cycles until rows are consumed;
    // lane i mirrors the read strobe i+1 cycles later; done lands LANES+1
    // cycles after the last read (or the cycle after start for zero rows).
    task automatic run_job(input job_t jb, output int done_at, output int nreads);
        bit          hist [256];
        int          reads;
        int          last;
        int          done_cyc;
        bit          issuing;
        bit          ready;
        bit          exp_rd;
        logic [3:0]  lanes_exp;
        logic [15:0] exp_addr;
        bit          finished;
        foreach (hist[k]) hist[k] = 1'b0;
        reads    = 0;
        last     = -1;
        done_at  = -1;
        nreads   = 0;
        finished = 1'b0;
        @(posedge clk);
        #1;
        start_in       = 1'b1;
        num_rows_in    = ROW_W'(jb.rows);
        base_addr_in   = jb.base;
        leak_factor_in = jb.leak;
        ub_ready_in    = 1'($urandom);
        @(negedge clk);
        check("idle_before_start", 0, 64'(busy_out), 64'd0);
        for (int j = 1; j < 200; j++) begin
            if (jb.rows == 0) done_cyc = 1;
            else if (last >= 0) done_cyc = last + LANES + 1;
            else done_cyc = 1000;
            @(posedge clk);
            #1;
            issuing = (jb.rows != 0) && (reads < jb.rows);
            if (issuing) ready = (j - 1 < 64) ? jb.mask[j-1] : 1'b1;
            else ready = 1'($urandom);
            ub_ready_in = ready;
            start_in    = (j == jb.inj) && (j <= done_cyc);
            if (start_in) begin
                num_rows_in    = 8'd7;
                leak_factor_in = 16'h1234;
                base_addr_in   = 16'($urandom);
            end else begin
                num_rows_in    = ROW_W'($urandom);
                leak_factor_in = 16'($urandom);
                base_addr_in   = 16'($urandom);
            end
            exp_rd  = issuing && ready;
            hist[j] = exp_rd;
            for (int i = 0; i < LANES; i++) begin
                lanes_exp[i] = (j - 1 - i >= 1) ? hist[j-1-i] : 1'b0;
            end
            exp_addr = jb.base + 16'(reads);
            @(negedge clk);
            check("rd_en", j, 64'(rd_en_out), 64'(exp_rd));
            if (issuing) check("rd_addr", j, 64'(rd_addr_out), 64'(exp_addr));
            check("lane_valid", j, 64'(lane_valid_out), 64'(lanes_exp));
            check("leak_factor", j, 64'(leak_factor_out), 64'(jb.leak));
            check("busy", j, 64'(busy_out), 64'(j <= done_cyc));
            check("done", j, 64'(done_out), 64'(j == done_cyc));
            if (rd_en_out) nreads++;
            if (done_out && done_at < 0) done_at = j;
            if (exp_rd) begin
                reads++;
                if (reads == jb.rows) last = j;
            end
            if (j == done_cyc + 1) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) check("job_timeout", 200, 64'd0, 64'd1);
        #1;
        start_in = 1'b0;
    endtask

    job_t table_q [$];
    int   d_at;
    int   n_rd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        table_q.push_back('{3, 16'h0010, 16'h0080, '1, 0, 8, 3});
        table_q.push_back('{4, 16'h0200, 16'h0040, ~64'h2, 0, 10, 4});
        table_q.push_back('{0, 16'h0100, 16'hFF00, '1, 0, 1, 0});
        table_q.push_back('{3, 16'h0030, 16'h0080, '1, 2, 8, 3});
        table_q.push_back('{3, 16'hFFFE, 16'h7FFF, '1, 0, 8, 3});
        table_q.push_back('{2, 16'h0001, 16'h8000, '1, 7, 7, 2});
        table_q.push_back('{0, 16'h0005, 16'h0101, '1, 1, 1, 0});

        // Reset held with random inputs: everything stays at zero.
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            start_in       = 1'($urandom);
            num_rows_in    = ROW_W'($urandom);
            base_addr_in   = 16'($urandom);
            leak_factor_in = 16'($urandom);
            ub_ready_in    = 1'($urandom);
            @(negedge clk);
            check("reset_hold", c, all_outs(), 64'd0);
        end
        @(posedge clk);
        #1;
        start_in = 1'b0;
        rst_n    = 1'b1;

        foreach (table_q[t]) begin
            run_job(table_q[t], d_at, n_rd);
            check("table_done_cycle", t, 64'(d_at), 64'(table_q[t].exp_done));
            check("table_read_count", t, 64'(n_rd), 64'(table_q[t].exp_reads));
        end

        // Asynchronous reset in the middle of ISSUE.
        @(posedge clk);
        #1;
        start_in       = 1'b1;
        num_rows_in    = 8'd5;
        base_addr_in   = 16'h0040;
        leak_factor_in = 16'h0080;
        ub_ready_in    = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        @(posedge clk);
        #2;
        check("pre_reset_busy", 0, 64'(busy_out), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset", 0, all_outs(), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("post_reset_quiet", c, {62'd0, busy_out, done_out}, 64'd0);
        end

        for (int r = 0; r < 30; r++) begin
            job_t jb;
            jb.rows      = $urandom_range(0, 12);
            jb.base      = 16'($urandom);
            jb.leak      = 16'($urandom);
            jb.mask      = {$urandom, $urandom} | {$urandom, $urandom};
            jb.inj       = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0;
            jb.exp_done  = 0;
            jb.exp_reads = jb.rows;
            run_job(jb, d_at, n_rd);
            check("rand_read_count", r, 64'(n_rd), 64'(jb.rows));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
